// File: rtl/g_reg_file_sb.sv
// General-register file with a per-register pending-write counter scoreboard, 2 read / 2 write-back ports.
// Reads, hazard, full and busy are combinational (0 cycles); write-backs and reservations land at the edge.
module g_reg_file_sb #(
  parameter int W_OPR   = 32,
  parameter int REG_N   = 16,
  parameter int W_RD    = $clog2(REG_N),
  parameter int CNT_W   = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_i,
  input  logic [W_RD-1:0]  rd_i,
  input  logic [W_RD-1:0]  r0_i,
  input  logic [W_RD-1:0]  r1_i,
  input  logic             rd_en0_i,
  input  logic             rd_en1_i,
  output logic [W_OPR-1:0] r_opr0_o,
  output logic [W_OPR-1:0] r_opr1_o,
  output logic             reserved_o,
  output logic             reserve_full_o,
  output logic             busy_o,
  input  logic             wb0_i,
  input  logic [W_RD-1:0]  wb0_r_i,
  input  logic [W_OPR-1:0] wb0_data_i,
  input  logic             wb1_i,
  input  logic [W_RD-1:0]  wb1_r_i,
  input  logic [W_OPR-1:0] wb1_data_i,
  input  logic             flush_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             ZR      = (ZERO_R0 != 0);
  localparam logic             BP      = (BYPASS != 0);

  logic [W_OPR-1:0] data_q [REG_N];
  logic [CNT_W-1:0] cnt_q  [REG_N];
  logic [CNT_W-1:0] cnt_d  [REG_N];

  logic acc;
  logic wb0_we;
  logic wb1_we;

  assign reserve_full_o = (cnt_q[rd_i] == CNT_MAX);
  assign acc    = issue_i && !reserve_full_o && !(ZR && rd_i == '0);
  assign wb0_we = wb0_i && !(ZR && wb0_r_i == '0);
  assign wb1_we = wb1_i && !(ZR && wb1_r_i == '0);

  // inc is only possible below CNT_MAX, so sum always fits back into CNT_W bits
  for (genvar r = 0; r < REG_N; r++) begin : g_cnt
    logic             inc;
    logic [CNT_W:0]   dec;
    logic [CNT_W:0]   sum;
    assign inc = acc && (rd_i == W_RD'(r));
    assign dec = (CNT_W+1)'(wb0_i && (wb0_r_i == W_RD'(r)))
               + (CNT_W+1)'(wb1_i && (wb1_r_i == W_RD'(r)));
    assign sum = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
    assign cnt_d[r] = flush_i     ? '0 :
                      (sum > dec) ? CNT_W'(sum - dec) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_N; r++) begin
        cnt_q[r]  <= '0;
        data_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_N; r++) begin
        cnt_q[r] <= cnt_d[r];
        if (wb1_we && wb1_r_i == W_RD'(r)) begin
          data_q[r] <= wb1_data_i;
        end else if (wb0_we && wb0_r_i == W_RD'(r)) begin
          data_q[r] <= wb0_data_i;
        end
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < REG_N; r++) begin
      busy_o = busy_o | (cnt_q[r] != '0);
    end
  end

  logic [W_RD-1:0]  rp_addr [2];
  logic             rp_en   [2];
  logic             rp_m0   [2];
  logic             rp_m1   [2];
  logic [CNT_W:0]   rp_nm   [2];
  logic [W_OPR-1:0] rp_dat  [2];
  logic             rp_haz  [2];

  assign rp_addr[0] = r0_i;
  assign rp_addr[1] = r1_i;
  assign rp_en[0]   = rd_en0_i;
  assign rp_en[1]   = rd_en1_i;

  // A bypassed write-back retires one pending write for hazard purposes
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rp_m0[p]  = BP && wb0_i && (wb0_r_i == rp_addr[p]) && !(ZR && rp_addr[p] == '0);
      rp_m1[p]  = BP && wb1_i && (wb1_r_i == rp_addr[p]) && !(ZR && rp_addr[p] == '0);
      rp_nm[p]  = (CNT_W+1)'(rp_m0[p]) + (CNT_W+1)'(rp_m1[p]);
      rp_dat[p] = data_q[rp_addr[p]];
      if (rp_m1[p]) begin
        rp_dat[p] = wb1_data_i;
      end else if (rp_m0[p]) begin
        rp_dat[p] = wb0_data_i;
      end
      if (ZR && rp_addr[p] == '0) begin
        rp_dat[p] = '0;
      end
      rp_haz[p] = rp_en[p] && ({1'b0, cnt_q[rp_addr[p]]} > rp_nm[p]);
    end
  end

  assign r_opr0_o   = rp_dat[0];
  assign r_opr1_o   = rp_dat[1];
  assign reserved_o = rp_haz[0] | rp_haz[1];

endmodule

// File: tb/tb_g_reg_file_sb.sv
// Two instances (ZERO_R0=0/BYPASS=1 and ZERO_R0=1/BYPASS=0) driven identically against a reference model.
module tb_g_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue, rd_en0, rd_en1, wb0, wb1, flush;
  logic [3:0]  rd, r0, r1, wb0_r, wb1_r;
  logic [31:0] wb0_data, wb1_data;
  logic [31:0] a_opr0, a_opr1, b_opr0, b_opr1;
  logic        a_res, a_full, a_busy, b_res, b_full, b_busy;

  int checks = 0;
  int errors = 0;

  int          zr [2] = '{0, 1};
  int          bp [2] = '{1, 0};
  int          m_cnt  [2][16];
  logic [31:0] m_data [2][16];

  always #5 clk = ~clk;

  g_reg_file_sb #(.ZERO_R0(0), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .issue_i(issue), .rd_i(rd), .r0_i(r0), .r1_i(r1),
    .rd_en0_i(rd_en0), .rd_en1_i(rd_en1), .r_opr0_o(a_opr0), .r_opr1_o(a_opr1),
    .reserved_o(a_res), .reserve_full_o(a_full), .busy_o(a_busy),
    .wb0_i(wb0), .wb0_r_i(wb0_r), .wb0_data_i(wb0_data),
    .wb1_i(wb1), .wb1_r_i(wb1_r), .wb1_data_i(wb1_data), .flush_i(flush));

  g_reg_file_sb #(.ZERO_R0(1), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .issue_i(issue), .rd_i(rd), .r0_i(r0), .r1_i(r1),
    .rd_en0_i(rd_en0), .rd_en1_i(rd_en1), .r_opr0_o(b_opr0), .r_opr1_o(b_opr1),
    .reserved_o(b_res), .reserve_full_o(b_full), .busy_o(b_busy),
    .wb0_i(wb0), .wb0_r_i(wb0_r), .wb0_data_i(wb0_data),
    .wb1_i(wb1), .wb1_r_i(wb1_r), .wb1_data_i(wb1_data), .flush_i(flush));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
    if (zr[k] != 0 && a == 0) return 32'h0;
    if (bp[k] != 0 && wb1 && wb1_r == a) return wb1_data;
    if (bp[k] != 0 && wb0 && wb0_r == a) return wb0_data;
    return m_data[k][a];
  endfunction

  function automatic bit exp_haz(int k, logic [3:0] a, logic e);
    int n = 0;
    if (bp[k] != 0 && !(zr[k] != 0 && a == 0)) begin
      if (wb0 && wb0_r == a) n++;
      if (wb1 && wb1_r == a) n++;
    end
    return e && (m_cnt[k][a] > n);
  endfunction

  function automatic bit exp_busy(int k);
    for (int r = 0; r < 16; r++) if (m_cnt[k][r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 16; r++) begin
        m_cnt[k][r]  = 0;
        m_data[k][r] = 32'h0;
      end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit acc = issue && (m_cnt[k][rd] != 3) && !(zr[k] != 0 && rd == 0);
      for (int r = 0; r < 16; r++) begin
        int v = m_cnt[k][r];
        if (acc && rd == r) v++;
        if (wb0 && wb0_r == r) v--;
        if (wb1 && wb1_r == r) v--;
        m_cnt[k][r] = flush ? 0 : (v < 0 ? 0 : v);
      end
      if (wb0 && !(zr[k] != 0 && wb0_r == 0)) m_data[k][wb0_r] = wb0_data;
      if (wb1 && !(zr[k] != 0 && wb1_r == 0)) m_data[k][wb1_r] = wb1_data;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":a_opr0"}, a_opr0, exp_rd(0, r0));
    chk({tag, ":a_opr1"}, a_opr1, exp_rd(0, r1));
    chk({tag, ":a_res"},  32'(a_res),  32'(exp_haz(0, r0, rd_en0) | exp_haz(0, r1, rd_en1)));
    chk({tag, ":a_full"}, 32'(a_full), 32'(m_cnt[0][rd] == 3));
    chk({tag, ":a_busy"}, 32'(a_busy), 32'(exp_busy(0)));
    chk({tag, ":b_opr0"}, b_opr0, exp_rd(1, r0));
    chk({tag, ":b_opr1"}, b_opr1, exp_rd(1, r1));
    chk({tag, ":b_res"},  32'(b_res),  32'(exp_haz(1, r0, rd_en0) | exp_haz(1, r1, rd_en1)));
    chk({tag, ":b_full"}, 32'(b_full), 32'(m_cnt[1][rd] == 3));
    chk({tag, ":b_busy"}, 32'(b_busy), 32'(exp_busy(1)));
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    issue = 0; rd = 0; r0 = 0; r1 = 0; rd_en0 = 0; rd_en1 = 0;
    wb0 = 0; wb0_r = 0; wb0_data = 0; wb1 = 0; wb1_r = 0; wb1_data = 0; flush = 0;
  endtask

  task automatic iss(input logic [3:0] r);
    idle(); issue = 1; rd = r;
  endtask

  task automatic do_wb0(input logic [3:0] r, input logic [31:0] d);
    idle(); wb0 = 1; wb0_r = r; wb0_data = d;
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    step("in_reset");
    reset = 1;
    idle(); r0 = 5; rd_en0 = 1;
    #1; chk("idle_r5", a_opr0, 32'h0);
    step("idle");

    iss(3); step("iss3");
    idle(); r0 = 3; rd_en0 = 1;
    #1; chk("haz3_res", 32'(a_res), 32'd1); chk("haz3_busy", 32'(a_busy), 32'd1);
    step("haz3");
    do_wb0(3, 32'hDEADBEEF); r0 = 3; rd_en0 = 1;
    #1; chk("byp_data", a_opr0, 32'hDEADBEEF); chk("byp_res", 32'(a_res), 32'd0);
    chk("nobyp_res", 32'(b_res), 32'd1);
    step("wb3");
    idle(); r0 = 3; rd_en0 = 1;
    #1; chk("nobyp_res_next", 32'(b_res), 32'd0); chk("nobyp_data", b_opr0, 32'hDEADBEEF);
    step("after_wb3");

    for (int i = 0; i < 3; i++) begin iss(7); step("iss7"); end
    iss(7);
    #1; chk("full7", 32'(a_full), 32'd1);
    step("iss7_refused");
    idle(); rd = 7; r0 = 7; rd_en0 = 1;
    #1; chk("still_full7", 32'(a_full), 32'd1);
    step("full7_hold");
    for (int i = 0; i < 3; i++) begin do_wb0(7, 32'h700 + i); step("wb7"); end
    idle();
    #1; chk("drain7_busy", 32'(a_busy), 32'd0); chk("drain7_busy_b", 32'(b_busy), 32'd0);
    step("drain7");

    iss(4); step("iss4");
    iss(4); wb0 = 1; wb0_r = 4; wb0_data = 32'h4444; step("iss_wb4");
    idle(); r0 = 4; rd_en0 = 1;
    #1; chk("cnt4_kept", 32'(b_res), 32'd1);
    step("rd4");
    do_wb0(4, 32'h4445); step("wb4");
    iss(9); step("iss9a");
    iss(9); step("iss9b");
    idle(); wb0 = 1; wb0_r = 9; wb0_data = 32'h9090; wb1 = 1; wb1_r = 9; wb1_data = 32'h9191;
    step("wb9_both");
    idle(); r0 = 9; rd_en0 = 1;
    #1; chk("r9_data", b_opr0, 32'h9191); chk("r9_res", 32'(b_res), 32'd0);
    step("rd9");

    iss(10); step("iss10");
    idle(); r1 = 10; rd_en1 = 0;
    #1; chk("en1_off", 32'(a_res), 32'd0);
    step("en1_off");
    do_wb0(10, 32'hA0A0); step("wb10");

    iss(0); step("iss0");
    idle(); r0 = 0; rd_en0 = 1;
    #1; chk("r0_not_res", 32'(b_res), 32'd0);
    step("rd0_res");
    do_wb0(0, 32'h55); step("wb0_55");
    idle(); r0 = 0; rd_en0 = 1;
    #1; chk("r0_zero", b_opr0, 32'h0);
    step("rd0");
    iss(2); step("iss2");
    iss(5); step("iss5");
    do_wb0(2, 32'h2222CAFE); flush = 1; issue = 1; rd = 6; step("flush");
    idle(); r0 = 2; rd_en0 = 1;
    #1; chk("flush_busy", 32'(a_busy), 32'd0); chk("flush_data", b_opr0, 32'h2222CAFE);
    step("after_flush");

    iss(6); step("iss6");
    iss(8); step("iss8");
    idle(); reset = 0; model_reset();
    #1; chk("midrst_busy", 32'(a_busy), 32'd0);
    step("mid_reset");
    reset = 1;
    step("post_reset");

    for (int i = 0; i < 1500; i++) begin
      issue    = ($urandom_range(0, 1) == 1);
      rd       = 4'($urandom_range(0, 7));
      r0       = 4'($urandom_range(0, 7));
      r1       = 4'($urandom_range(0, 15));
      rd_en0   = ($urandom_range(0, 3) != 0);
      rd_en1   = ($urandom_range(0, 1) == 1);
      wb0      = ($urandom_range(0, 2) == 0);
      wb0_r    = 4'($urandom_range(0, 7));
      wb0_data = $urandom;
      wb1      = ($urandom_range(0, 3) == 0);
      wb1_r    = 4'($urandom_range(0, 7));
      wb1_data = $urandom;
      flush    = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
